papa_uart_rx: RTL and testbench

- Asynchronous serial (UART-style) receiver for the papa example design.
- Samples a 1-start/N-data/optional-parity/1-stop line at a fixed oversampling ratio.
- Delivers each received word on a valid/ready output stream with per-word error flags.
- Sits at the far end of the serial link driven by the papa transmitter; feeds a core consumer in the clk domain.

---
 rtl/papa_uart_pkg.sv | 22 ++
 rtl/papa_sync2.sv | 23 ++
 rtl/papa_uart_rx.sv | 158 +++++++++++++++
 tb/tb_papa_uart_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/papa_uart_pkg.sv
// Shared definitions for the papa serial link (receiver and transmitter).
package papa_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } uart_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Words narrower than 9 bits are zero-padded, which leaves the XOR unchanged.
   function automatic logic expected_parity(input logic [8:0] data, input int mode);
      return (mode == PAR_ODD) ? ~(^data) : (^data);
   endfunction

endpackage

// File: rtl/papa_sync2.sv
// Two-flop single-bit synchronizer for bringing an asynchronous level into clk.
module papa_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/papa_uart_rx.sv
// UART receiver: mid-bit sampling of start/data/parity/stop, single-entry
// valid/ready output register with parity, framing and overrun reporting.
module papa_uart_rx
   import papa_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8,
   parameter int PARITY       = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rxd,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              par_err,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_W + 1);

   localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
   localparam logic             HAS_PAR  = (PARITY != PAR_NONE);

   logic              rxd_s;
   logic              rxd_prev;
   uart_state_t       state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] shreg;
   logic              perr;

   logic              strobe;
   logic              fall;
   logic [8:0]        data_pad;
   logic              exp_par;

   papa_sync2 #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rxd),
      .q     (rxd_s)
   );

   assign strobe   = (cnt == '0);
   assign fall     = rxd_prev & ~rxd_s;
   assign data_pad = 9'(shreg);
   assign exp_par  = expected_parity(data_pad, PARITY);
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_prev  <= 1'b1;
         state     <= ST_IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         perr      <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         par_err   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         rxd_prev <= rxd_s;
         overrun  <= 1'b0;

         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (fall) begin
                  state <= ST_START;
                  cnt   <= HALF_BIT;
               end
            end

            ST_START: begin
               if (strobe) begin
                  cnt <= FULL_BIT;
                  if (rxd_s) begin
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_DATA;
                     idx   <= '0;
                     perr  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            ST_DATA: begin
               if (strobe) begin
                  cnt   <= FULL_BIT;
                  shreg <= {rxd_s, shreg[DATA_W-1:1]};
                  if (idx == LAST_IDX) begin
                     state <= HAS_PAR ? ST_PARITY : ST_STOP;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            ST_PARITY: begin
               if (strobe) begin
                  cnt   <= FULL_BIT;
                  perr  <= (rxd_s != exp_par);
                  state <= ST_STOP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            ST_STOP: begin
               if (strobe) begin
                  cnt   <= '0;
                  state <= rxd_s ? ST_IDLE : ST_BREAK;
                  // A completing word may replace the held one only if it is
                  // being consumed in this same cycle.
                  if (!rx_valid || rx_ready) begin
                     rx_data   <= shreg;
                     par_err   <= perr & HAS_PAR;
                     frame_err <= ~rxd_s;
                     rx_valid  <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            ST_BREAK: begin
               if (rxd_s) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_papa_uart_rx.sv
// Directed bench for papa_uart_rx: even-parity and odd-parity instances.
module tb_papa_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rxd_e, rxd_o;
   logic       ready_e, ready_o;
   logic [7:0] data_e, data_o;
   logic       valid_e, valid_o;
   logic       perr_e, perr_o;
   logic       ferr_e, ferr_o;
   logic       ovr_e, ovr_o;
   logic       busy_e, busy_o;

   always #5 clk = ~clk;

   papa_uart_rx #(.CLKS_PER_BIT(16), .DATA_W(8), .PARITY(1)) dut_e (
      .clk (clk), .rst_n (rst_n), .rxd (rxd_e),
      .rx_data (data_e), .rx_valid (valid_e), .rx_ready (ready_e),
      .par_err (perr_e), .frame_err (ferr_e), .overrun (ovr_e), .busy (busy_e)
   );

   papa_uart_rx #(.CLKS_PER_BIT(16), .DATA_W(8), .PARITY(2)) dut_o (
      .clk (clk), .rst_n (rst_n), .rxd (rxd_o),
      .rx_data (data_o), .rx_valid (valid_o), .rx_ready (ready_o),
      .par_err (perr_o), .frame_err (ferr_o), .overrun (ovr_o), .busy (busy_o)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Handshake / overrun log for both instances, sampled mid-cycle.
   int         vcnt_e = 0, hs_cnt_e = 0, hs_cyc_e = 0, ov_cnt_e = 0, ov_cyc_e = 0;
   logic [7:0] hs_data_e = '0;
   logic       hs_perr_e = 1'b0, hs_ferr_e = 1'b0;
   int         hs_cnt_o = 0, ov_cnt_o = 0;
   logic [7:0] hs_data_o = '0;
   logic       hs_perr_o = 1'b0, hs_ferr_o = 1'b0;

   always @(negedge clk) begin
      if (valid_e) vcnt_e <= vcnt_e + 1;
      if (valid_e && ready_e) begin
         hs_cnt_e  <= hs_cnt_e + 1;
         hs_cyc_e  <= cyc;
         hs_data_e <= data_e;
         hs_perr_e <= perr_e;
         hs_ferr_e <= ferr_e;
      end
      if (ovr_e) begin
         ov_cnt_e <= ov_cnt_e + 1;
         ov_cyc_e <= cyc;
      end
      if (valid_o && ready_o) begin
         hs_cnt_o  <= hs_cnt_o + 1;
         hs_data_o <= data_o;
         hs_perr_o <= perr_o;
         hs_ferr_o <= ferr_o;
      end
      if (ovr_o) ov_cnt_o <= ov_cnt_o + 1;
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit odd_dut, input logic v);
      if (odd_dut) rxd_o = v;
      else         rxd_e = v;
   endtask

   // Called at a falling clock edge; returns the cycle the start bit was driven.
   task automatic send(input bit odd_dut, input logic [7:0] d, input logic pbit,
                       input logic sbit, output int t_start);
      t_start = cyc;
      drive(odd_dut, 1'b0);
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive(odd_dut, d[i]);
         repeat (16) @(negedge clk);
      end
      drive(odd_dut, pbit);
      repeat (16) @(negedge clk);
      drive(odd_dut, sbit);
      repeat (16) @(negedge clk);
   endtask

   initial begin
      int t, t2, v0, h0, o0;
      logic [7:0] pat;

      rst_n   = 1'b0;
      rxd_e   = 1'b1;
      rxd_o   = 1'b1;
      ready_e = 1'b1;
      ready_o = 1'b1;
      repeat (3) @(negedge clk);

      check("reset_data",  32'(data_e),  32'h0);
      check("reset_valid", 32'(valid_e), 32'h0);
      check("reset_perr",  32'(perr_e),  32'h0);
      check("reset_ferr",  32'(ferr_e),  32'h0);
      check("reset_ovr",   32'(ovr_e),   32'h0);
      check("reset_busy",  32'(busy_e),  32'h0);

      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Clean frame 0xA5, even parity bit 0; line falls at t, T0 = t+2.
      v0 = vcnt_e; h0 = hs_cnt_e;
      send(1'b0, 8'hA5, 1'b0, 1'b1, t);
      repeat (8) @(negedge clk);
      check("clean_count",      32'(hs_cnt_e - h0), 32'd1);
      check("clean_valid_cyc",  32'(hs_cyc_e),      32'(t + 171));
      check("clean_valid_len",  32'(vcnt_e - v0),   32'd1);
      check("clean_data",       32'(hs_data_e),     32'hA5);
      check("clean_perr",       32'(hs_perr_e),     32'h0);
      check("clean_ferr",       32'(hs_ferr_e),     32'h0);

      // Glitch: 4 cycles low; false start detected at T0+8.
      v0 = vcnt_e;
      t = cyc;
      rxd_e = 1'b0;
      repeat (4) @(negedge clk);
      rxd_e = 1'b1;
      repeat (6) @(negedge clk);
      check("glitch_busy_t8",  32'(busy_e), 32'h1);
      @(negedge clk);
      check("glitch_busy_t9",  32'(busy_e), 32'h0);
      repeat (200) @(negedge clk);
      check("glitch_no_valid", 32'(vcnt_e - v0), 32'd0);

      // Odd parity instance: 0x3C expects parity 1, send 0.
      h0 = hs_cnt_o;
      send(1'b1, 8'h3C, 1'b0, 1'b1, t);
      repeat (4) @(negedge clk);
      check("oddpar_count", 32'(hs_cnt_o - h0), 32'd1);
      check("oddpar_data",  32'(hs_data_o),     32'h3C);
      check("oddpar_perr",  32'(hs_perr_o),     32'h1);
      check("oddpar_ferr",  32'(hs_ferr_o),     32'h0);
      check("oddpar_busy",  32'(busy_o),        32'h0);

      // Framing error followed by 3 bit times of break.
      v0 = vcnt_e; h0 = hs_cnt_e;
      send(1'b0, 8'h55, 1'b0, 1'b0, t);
      repeat (48) @(negedge clk);
      rxd_e = 1'b1;
      repeat (40) @(negedge clk);
      check("break_count",     32'(hs_cnt_e - h0), 32'd1);
      check("break_valid_len", 32'(vcnt_e - v0),   32'd1);
      check("break_data",      32'(hs_data_e),     32'h55);
      check("break_ferr",      32'(hs_ferr_e),     32'h1);
      check("break_perr",      32'(hs_perr_e),     32'h0);

      h0 = hs_cnt_e;
      send(1'b0, 8'h12, 1'b0, 1'b1, t);
      repeat (4) @(negedge clk);
      check("after_break_count", 32'(hs_cnt_e - h0), 32'd1);
      check("after_break_data",  32'(hs_data_e),     32'h12);
      check("after_break_ferr",  32'(hs_ferr_e),     32'h0);

      // Back-pressure: 0x11 held, 0x22 dropped with an overrun pulse.
      ready_e = 1'b0;
      h0 = hs_cnt_e; o0 = ov_cnt_e;
      send(1'b0, 8'h11, 1'b0, 1'b1, t);
      send(1'b0, 8'h22, 1'b0, 1'b1, t2);
      repeat (4) @(negedge clk);
      check("bp_valid_held", 32'(valid_e),        32'h1);
      check("bp_data_held",  32'(data_e),         32'h11);
      check("bp_ovr_count",  32'(ov_cnt_e - o0),  32'd1);
      check("bp_ovr_cyc",    32'(ov_cyc_e),       32'(t2 + 171));
      check("bp_no_hs",      32'(hs_cnt_e - h0),  32'd0);
      @(posedge clk);
      #1 ready_e = 1'b1;
      repeat (4) @(negedge clk);
      check("bp_release_count", 32'(hs_cnt_e - h0), 32'd1);
      check("bp_release_data",  32'(hs_data_e),     32'h11);
      check("bp_release_valid", 32'(valid_e),       32'h0);

      // Reset during data bit 4 of 0x77.
      pat = 8'h77;
      rxd_e = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rxd_e = pat[i];
         repeat (16) @(negedge clk);
      end
      rxd_e = pat[4];
      repeat (8) @(negedge clk);
      check("midrst_busy_before", 32'(busy_e), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_data",  32'(data_e),  32'h0);
      check("midrst_valid", 32'(valid_e), 32'h0);
      check("midrst_busy",  32'(busy_e),  32'h0);
      check("midrst_perr",  32'(perr_e),  32'h0);
      check("midrst_ferr",  32'(ferr_e),  32'h0);
      check("midrst_ovr",   32'(ovr_e),   32'h0);
      rxd_e = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      h0 = hs_cnt_e;
      send(1'b0, 8'h81, 1'b0, 1'b1, t);
      repeat (4) @(negedge clk);
      check("post_rst_count", 32'(hs_cnt_e - h0), 32'd1);
      check("post_rst_data",  32'(hs_data_e),     32'h81);
      check("post_rst_perr",  32'(hs_perr_e),     32'h0);
      check("post_rst_ferr",  32'(hs_ferr_e),     32'h0);
      check("odd_no_overrun", 32'(ov_cnt_o),      32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
